// File: rtl/codec2_fixed_pkg.sv
// Shared fixed-point constants, FIR sequencer states and sign-magnitude /
// two's-complement helpers for the CODEC2 2400 encode datapath.
package codec2_fixed_pkg;

  localparam int N         = 80;
  localparam int FRAC      = 18;
  localparam int NLP_NTAPS = 48;
  localparam int ACCW      = 2 * N + 6;
  localparam int NLP_KW    = 6;

  localparam logic [N-2:0] MAG_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  // Negative zero folds to 0 because -0 == 0 in two's complement.
  function automatic logic signed [N-1:0] sm_to_tc(input logic [N-1:0] sm);
    logic signed [N-1:0] mag;
    mag = {1'b0, sm[N-2:0]};
    return sm[N-1] ? -mag : mag;
  endfunction

  function automatic logic [N-1:0] tc_to_sm_sat(input logic signed [ACCW-1:0] v);
    logic signed [ACCW-1:0] lim;
    logic signed [ACCW-1:0] neg;
    lim = {{(ACCW-N+1){1'b0}}, MAG_MAX};
    if (v > lim) return {1'b0, MAG_MAX};
    if (v < -lim) return {1'b1, MAG_MAX};
    if (v[ACCW-1]) begin
      neg = -v;
      return {1'b1, neg[N-2:0]};
    end
    return {1'b0, v[N-2:0]};
  endfunction

endpackage

// File: rtl/sm_tc_conv.sv
// Bidirectional sign-magnitude / two's-complement converter; the
// two's-complement to sign-magnitude direction saturates the magnitude.
module sm_tc_conv
  import codec2_fixed_pkg::*;
(
  input  logic        [N-1:0]    i_sm,
  output logic signed [N-1:0]    o_tc,
  input  logic signed [ACCW-1:0] i_tc,
  output logic        [N-1:0]    o_sm
);

  assign o_tc = sm_to_tc(i_sm);
  assign o_sm = tc_to_sm_sat(i_tc);

endmodule

// File: rtl/nlp_fir_filter.sv
// 48-tap sign-magnitude FIR for the NLP pitch estimator, one MAC per cycle
// against the external ROM_nlp_fir. Define NLP_FIR_ROUND_EN for round-half-up.
module nlp_fir_filter
  import codec2_fixed_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        sample_in,
  output logic [NLP_KW-1:0]   coef_addr,
  input  logic [N-1:0]        coef_data,
  output logic                out_valid,
  output logic [N-1:0]        sample_out,
  output logic                busy
);

  fir_state_e r_state;
  fir_state_e w_state_next;

  logic [N-1:0]           r_dl [NLP_NTAPS];
  logic signed [ACCW-1:0] r_acc;
  logic [NLP_KW-1:0]      r_k;
  logic [N-1:0]           r_sample_out;

  logic                   w_accept;
  logic                   w_last;
  logic [N-1:0]           w_tap;
  logic signed [N-1:0]    w_tap_tc;
  logic signed [N-1:0]    w_coef_tc;
  logic signed [2*N-1:0]  w_tap_x;
  logic signed [2*N-1:0]  w_coef_x;
  logic signed [2*N-1:0]  w_prod;
  logic signed [ACCW-1:0] w_acc_next;
  logic signed [ACCW-1:0] w_acc_rnd;
  logic signed [ACCW-1:0] w_acc_shr;
  logic [N-1:0]           w_out_sm;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_last   = (r_k == NLP_KW'(NLP_NTAPS - 1));
  assign w_tap    = r_dl[r_k];

  sm_tc_conv u_conv (
    .i_sm (w_tap),
    .o_tc (w_tap_tc),
    .i_tc (w_acc_shr),
    .o_sm (w_out_sm)
  );

  assign w_coef_tc  = sm_to_tc(coef_data);
  assign w_tap_x    = {{N{w_tap_tc[N-1]}}, w_tap_tc};
  assign w_coef_x   = {{N{w_coef_tc[N-1]}}, w_coef_tc};
  assign w_prod     = w_tap_x * w_coef_x;
  assign w_acc_next = r_acc + {{(ACCW-2*N){w_prod[2*N-1]}}, w_prod};

`ifdef NLP_FIR_ROUND_EN
  localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(1) << (FRAC - 1);
  assign w_acc_rnd = w_acc_next + RND_HALF;
`else
  assign w_acc_rnd = w_acc_next;
`endif

  // Arithmetic shift floors toward -inf; saturation happens in the converter.
  assign w_acc_shr = w_acc_rnd >>> FRAC;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output gets a default first so no case path infers a latch.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    out_valid    = 1'b0;
    coef_addr    = '0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = MAC;
      end
      MAC: begin
        busy      = 1'b1;
        coef_addr = r_k;
        if (w_last) w_state_next = OUT;
      end
      OUT: begin
        busy         = 1'b1;
        out_valid    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: the delay line is reset because the zero-history startup depends on it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NLP_NTAPS; i++) r_dl[i] <= '0;
      r_acc        <= '0;
      r_k          <= '0;
      r_sample_out <= '0;
    end else if (w_accept) begin
      r_dl[0] <= sample_in;
      for (int i = 1; i < NLP_NTAPS; i++) r_dl[i] <= r_dl[i-1];
      r_acc <= '0;
      r_k   <= '0;
    end else if (r_state == MAC) begin
      r_acc <= w_acc_next;
      r_k   <= r_k + NLP_KW'(1);
      // Result is registered on the final MAC edge so it is stable during OUT.
      if (w_last) r_sample_out <= w_out_sm;
    end
  end

  assign sample_out = r_sample_out;

endmodule

// File: tb/tb_nlp_fir_filter.sv
// Directed self-checking bench for nlp_fir_filter with a small ROM_nlp_fir
// model; rounding expectations follow NLP_FIR_ROUND_EN.
module tb_nlp_fir_filter;
  import codec2_fixed_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N-1:0]      sample_in = '0;
  logic [NLP_KW-1:0] coef_addr;
  logic [N-1:0]      coef_data;
  logic              out_valid;
  logic [N-1:0]      sample_out;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [N-1:0] NEG_ZERO = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONE      = 80'h1 << FRAC;
  localparam logic [N-1:0] NEG_ONE  = ONE | NEG_ZERO;
  localparam logic [N-1:0] HALF     = 80'h1 << (FRAC - 1);
  localparam logic [N-1:0] NEG_HALF = HALF | NEG_ZERO;
  localparam logic [N-1:0] MAX_POS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MAX_NEG  = '1;

  nlp_fir_filter dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sample_in  (sample_in),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .out_valid  (out_valid),
    .sample_out (sample_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] sm(input logic s, input logic [N-2:0] m);
    return {s, m};
  endfunction

  // Symmetric test ROM: -0x46 at the ends, 0x260F at the centre, negative
  // zero at taps 2/45, 0x3000 elsewhere (DC gain above 1.0).
  function automatic logic [N-1:0] rom_word(input int k);
    if (k == 0 || k == NLP_NTAPS - 1) return sm(1'b1, 79'h46);
    if (k == 23 || k == 24) return sm(1'b0, 79'h260F);
    if (k == 2 || k == 45) return NEG_ZERO;
    if (k < NLP_NTAPS) return sm(1'b0, 79'h3000);
    return '0;
  endfunction

  assign coef_data = rom_word(int'(coef_addr));

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    sample_in = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  // Offers one sample, follows it for 55 cycles and returns the result.
  task automatic run_sample(input logic [N-1:0] s, input bit timing, output logic [N-1:0] y);
    int lat;
    int bad_addr;
    int bad_hs;
    int pulses;
    lat = -1;
    bad_addr = 0;
    bad_hs = 0;
    pulses = 0;
    y = '0;
    for (int w = 0; w < 60 && !in_ready; w++) step();
    in_valid = 1'b1;
    sample_in = s;
    step();
    in_valid = 1'b0;
    sample_in = '0;
    for (int c = 1; c <= 55; c++) begin
      if (c <= 48 && coef_addr != NLP_KW'(c - 1)) bad_addr++;
      if (c <= 49 && (in_ready || !busy)) bad_hs++;
      if (c == 50 && (!in_ready || busy)) bad_hs++;
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          y = sample_out;
        end
      end
      step();
    end
    check("latency", N'(lat), N'(49));
    if (timing) begin
      check("coef_addr_seq_errors", N'(bad_addr), '0);
      check("ready_busy_errors", N'(bad_hs), '0);
      check("out_valid_pulses", N'(pulses), N'(1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] y;
    logic [N-1:0] ys [NLP_NTAPS];
    logic [N-1:0] y0;
    logic [N-1:0] y1;
    int rc;
    int lat0;
    int lat1;
    int pulses;

    repeat (2) step();
    rst = 1'b0;
    step();
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), '0);
    check("rst_busy", N'(busy), '0);
    check("rst_coef_addr", N'(coef_addr), '0);
    check("rst_sample_out", sample_out, '0);

    // Impulse response reproduces the ROM words.
    for (int k = 0; k < NLP_NTAPS; k++) run_sample((k == 0) ? ONE : '0, (k == 0), ys[k]);
    check("impulse_out0", ys[0], sm(1'b1, 79'h46));
    check("impulse_out1", ys[1], sm(1'b0, 79'h3000));
    check("impulse_out2_negzero_coef", ys[2], '0);
    check("impulse_out23", ys[23], sm(1'b0, 79'h260F));
    check("impulse_out47", ys[47], sm(1'b1, 79'h46));

    // Reset held 3 cycles in the middle of a MAC sequence.
    in_valid = 1'b1;
    sample_in = ONE;
    step();
    in_valid = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("midrst_in_ready", N'(in_ready), N'(1));
    check("midrst_out_valid", N'(out_valid), '0);
    check("midrst_busy", N'(busy), '0);
    check("midrst_coef_addr", N'(coef_addr), '0);
    check("midrst_sample_out", sample_out, '0);
    pulses = 0;
    for (int c = 0; c < 60; c++) begin
      if (out_valid) pulses++;
      step();
    end
    check("midrst_spurious_pulses", N'(pulses), '0);

    // Busy handshake: junk offered while busy must be ignored.
    rc = -1;
    lat0 = -1;
    lat1 = -1;
    y0 = '0;
    y1 = '0;
    in_valid = 1'b1;
    sample_in = ONE;
    step();
    for (int c = 1; c <= 60; c++) begin
      if (out_valid && lat0 < 0) begin
        lat0 = c;
        y0 = sample_out;
      end
      if (in_ready) begin
        rc = c;
        break;
      end
      sample_in = MAX_POS ^ N'(c * 7919);
      step();
    end
    sample_in = NEG_ONE;
    step();
    in_valid = 1'b0;
    sample_in = '0;
    for (int c = 1; c <= 60; c++) begin
      if (out_valid && lat1 < 0) begin
        lat1 = c;
        y1 = sample_out;
      end
      step();
    end
    check("hs_first_latency", N'(lat0), N'(49));
    check("hs_first_out", y0, sm(1'b1, 79'h46));
    check("hs_next_accept_cycle", N'(rc), N'(50));
    check("hs_second_latency", N'(lat1), N'(49));
    check("hs_plus_minus_one_out", y1, sm(1'b0, 79'h3046));

    // Negated impulse.
    do_reset();
    for (int k = 0; k < 24; k++) run_sample((k == 0) ? NEG_ONE : '0, 1'b0, ys[k]);
    check("neg_impulse_out0", ys[0], sm(1'b0, 79'h46));
    check("neg_impulse_out23", ys[23], sm(1'b1, 79'h260F));

    // Negative zero input.
    do_reset();
    run_sample(NEG_ZERO, 1'b0, y);
    check("neg_zero_in", y, '0);

    // Full-scale inputs saturate with the right sign.
    do_reset();
    for (int k = 0; k < NLP_NTAPS; k++) run_sample(MAX_POS, 1'b0, y);
    check("sat_positive", y, MAX_POS);
    do_reset();
    for (int k = 0; k < NLP_NTAPS; k++) run_sample(MAX_NEG, 1'b0, y);
    check("sat_negative", y, MAX_NEG);

    // Half-LSB results on the centre tap: truncation floors, rounding goes up.
    do_reset();
    for (int k = 0; k < 24; k++) run_sample((k == 0) ? HALF : '0, 1'b0, ys[k]);
`ifdef NLP_FIR_ROUND_EN
    check("half_pos_tap23", ys[23], sm(1'b0, 79'h1308));
`else
    check("half_pos_tap23", ys[23], sm(1'b0, 79'h1307));
`endif
    do_reset();
    for (int k = 0; k < 24; k++) run_sample((k == 0) ? NEG_HALF : '0, 1'b0, ys[k]);
`ifdef NLP_FIR_ROUND_EN
    check("half_neg_tap23", ys[23], sm(1'b1, 79'h1307));
`else
    check("half_neg_tap23", ys[23], sm(1'b1, 79'h1308));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
